// File: rtl/mem_ctrl_pkg.sv
// Shared types and sizes for the cache-side unified-memory line controller.
// The state and requester-source enums are used by the top and its watchdog.
package mem_ctrl_pkg;

    localparam int LINE_AW = 14;
    localparam int LINE_DW = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WB_REQ  = 3'd1,
        ST_WB_WAIT = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_e;

    function automatic logic is_wait(input state_e s);
        return (s == ST_WB_WAIT) || (s == ST_RD_WAIT);
    endfunction

endpackage

// File: rtl/mem_wait_wdog.sv
// Counts cycles spent in a memory WAIT state and raises a sticky error
// once WAIT_LIMIT is reached; only reset clears the error.
module mem_wait_wdog
    import mem_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    output logic mem_err
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Counter restarts whenever the FSM is outside a WAIT state, so each
    // WAIT entry begins from zero; it saturates so it cannot wrap.
    always_comb begin
        cnt_d = '0;
        err_d = err_q;
        if (waiting) begin
            cnt_d = (cnt_q == CW'(WAIT_LIMIT)) ? cnt_q : cnt_q + 1'b1;
            if (cnt_d == CW'(WAIT_LIMIT)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign mem_err = err_q;

endmodule

// File: rtl/cache_mem_ctrl.sv
// Arbitrates I-cache fills and D-cache writeback/fills onto the unified memory,
// issuing one-cycle re/we strobes and returning registered 64-bit lines.
module cache_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int LINE_AW    = mem_ctrl_pkg::LINE_AW,
    parameter int LINE_DW    = mem_ctrl_pkg::LINE_DW,
    parameter int WAIT_LIMIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_req,
    input  logic [LINE_AW-1:0] i_line_addr,
    input  logic               d_req,
    input  logic [LINE_AW-1:0] d_line_addr,
    input  logic               d_dirty,
    input  logic [LINE_AW-1:0] d_vic_addr,
    input  logic [LINE_DW-1:0] d_vic_data,
    output logic               i_fill_vld,
    output logic               d_fill_vld,
    output logic [LINE_DW-1:0] fill_data,
    output logic               busy,
    output logic               mem_err,
    output logic [LINE_AW-1:0] mem_addr,
    output logic               mem_re,
    output logic               mem_we,
    output logic [LINE_DW-1:0] mem_wdata,
    input  logic [LINE_DW-1:0] mem_rd_data,
    input  logic               mem_rdy
);

    state_e             state_q, state_d;
    src_e               src_q, src_d;
    logic [LINE_AW-1:0] fill_addr_q, fill_addr_d;
    logic [LINE_AW-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_DW-1:0] fill_data_q, fill_data_d;
    logic [LINE_AW-1:0] sel_addr;
    logic               take;

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        fill_addr_d = fill_addr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_data_d = fill_data_q;
        take        = mem_rdy && (i_req || d_req);
        sel_addr    = d_req ? d_line_addr : i_line_addr;

        case (state_q)
            ST_IDLE: begin
                // mem_rdy gating also covers an op left running across a reset.
                if (take) begin
                    src_d       = d_req ? SRC_D : SRC_I;
                    fill_addr_d = sel_addr;
                    if (d_req && d_dirty) begin
                        state_d     = ST_WB_REQ;
                        mem_addr_d  = d_vic_addr;
                        mem_wdata_d = d_vic_data;
                    end else begin
                        state_d    = ST_RD_REQ;
                        mem_addr_d = sel_addr;
                    end
                end
            end
            ST_WB_REQ: begin
                state_d = ST_WB_WAIT;
            end
            ST_WB_WAIT: begin
                if (mem_rdy) begin
                    state_d    = ST_RD_REQ;
                    mem_addr_d = fill_addr_q;
                end
            end
            ST_RD_REQ: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (mem_rdy) begin
                    state_d     = ST_RESP;
                    fill_data_d = mem_rd_data;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            src_q       <= SRC_I;
            fill_addr_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            fill_data_q <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            fill_addr_q <= fill_addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            fill_data_q <= fill_data_d;
        end
    end

    mem_wait_wdog #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .waiting (is_wait(state_q)),
        .mem_err (mem_err)
    );

    // Moore outputs: strobes and fill pulses decode straight from the state register.
    assign mem_re     = (state_q == ST_RD_REQ);
    assign mem_we     = (state_q == ST_WB_REQ);
    assign i_fill_vld = (state_q == ST_RESP) && (src_q == SRC_I);
    assign d_fill_vld = (state_q == ST_RESP) && (src_q == SRC_D);
    assign busy       = (state_q != ST_IDLE);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign fill_data  = fill_data_q;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Scoreboard bench for cache_mem_ctrl with a 4-clock unified memory model.
`timescale 1ns/1ps
module tb_cache_mem_ctrl;

    localparam int AW    = 14;
    localparam int DW    = 64;
    localparam int LIMIT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_dirty;
    logic [AW-1:0] i_line_addr, d_line_addr, d_vic_addr;
    logic [DW-1:0] d_vic_data;
    logic          i_fill_vld, d_fill_vld, busy, mem_err, mem_re, mem_we;
    logic [DW-1:0] fill_data, mem_wdata, mem_rd_data;
    logic [AW-1:0] mem_addr;
    logic          mem_rdy;

    cache_mem_ctrl #(.LINE_AW(AW), .LINE_DW(DW), .WAIT_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_line_addr(i_line_addr),
        .d_req(d_req), .d_line_addr(d_line_addr), .d_dirty(d_dirty),
        .d_vic_addr(d_vic_addr), .d_vic_data(d_vic_data),
        .i_fill_vld(i_fill_vld), .d_fill_vld(d_fill_vld), .fill_data(fill_data),
        .busy(busy), .mem_err(mem_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rd_data(mem_rd_data), .mem_rdy(mem_rdy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wb_t;
    typedef struct { logic is_d; logic [DW-1:0] d; } fill_t;
    wb_t   wb_q[$];
    fill_t fill_q[$];

    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int stall_next = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_line(input int i);
        return {16'(i ^ 32'hA5A5), 16'(i * 3 + 1), 16'(~i), 16'(i + 7)};
    endfunction

    // Unified memory: busy for 4 clocks after a strobe, rdy rises in the 4th.
    initial begin
        int mcnt;
        logic m_we, skip_hold;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wdata;
        wb_t w;
        mcnt = 0; m_we = 0; skip_hold = 0; m_addr = '0; m_wdata = '0;
        for (int i = 0; i < (1<<AW); i++) mem[i] = init_line(i);
        mem[14'h0010] = 64'h0004_0003_0002_0001;
        mem_rdy <= 1'b1;
        mem_rd_data <= '0;
        forever begin
            @(posedge clk);
            if (mem_re || mem_we) begin
                check("re_we_exclusive", mem_re & mem_we, 0);
                check("strobe_while_mem_busy", mcnt != 0, 0);
            end
            if (mcnt == 0) begin
                if (mem_re || mem_we) begin
                    m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata; skip_hold = 0;
                    mcnt = 3 + (mem_re ? stall_next : 0);
                    mem_rdy <= 1'b0;
                    if (mem_re) rd_cnt++;
                    if (mem_we) begin
                        wr_cnt++;
                        if (wb_q.size() == 0) begin
                            vectors++; errors++;
                            $display("FAIL unexpected_we: addr %h", mem_addr);
                        end else begin
                            w = wb_q.pop_front();
                            check("wb_addr", mem_addr, w.a);
                            check("wb_data", mem_wdata, w.d);
                        end
                    end
                end
            end else begin
                if (rst) skip_hold = 1;
                if (mcnt == 1) begin
                    if (!skip_hold) begin
                        check("addr_held", mem_addr, m_addr);
                        if (m_we) check("wdata_held", mem_wdata, m_wdata);
                    end
                    if (m_we) mem[m_addr] = m_wdata;
                    else mem_rd_data <= mem[m_addr];
                    mem_rdy <= 1'b1;
                end
                mcnt--;
            end
        end
    end

    // Monitor: every fill pulse must match the oldest outstanding expectation.
    initial begin
        fill_t e;
        forever begin
            @(negedge clk);
            if (!rst && (i_fill_vld || d_fill_vld)) begin
                check("single_vld", i_fill_vld & d_fill_vld, 0);
                if (fill_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL unexpected_fill: i_vld %b d_vld %b data %h", i_fill_vld, d_fill_vld, fill_data);
                end else begin
                    e = fill_q.pop_front();
                    check("fill_src_d", d_fill_vld, e.is_d);
                    check("fill_data", fill_data, e.d);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // Reference: writeback lands before the fill; D is served before a simultaneous I.
    task automatic start_req(input logic do_i, input logic do_d, input logic dirty,
                             input logic [AW-1:0] ia, input logic [AW-1:0] da,
                             input logic [AW-1:0] va, input logic [DW-1:0] vd);
        if (do_d) begin
            if (dirty) begin
                wb_q.push_back('{a: va, d: vd});
                ref_mem[va] = vd;
            end
            fill_q.push_back('{is_d: 1'b1, d: ref_mem[da]});
        end
        if (do_i) fill_q.push_back('{is_d: 1'b0, d: ref_mem[ia]});
        i_line_addr = ia; d_line_addr = da; d_vic_addr = va; d_vic_data = vd;
        d_dirty = dirty; i_req = do_i; d_req = do_d;
    endtask

    task automatic wait_done(input int exp_d, input int exp_i, input int budget);
        int n = 0;
        int ld = -1;
        int li = -1;
        logic had_d = d_req;
        logic had_i = i_req;
        while ((i_req || d_req) && n < budget) begin
            @(negedge clk);
            n++;
            if (d_req && d_fill_vld) begin d_req = 0; ld = n; end
            if (i_req && i_fill_vld) begin i_req = 0; li = n; end
        end
        if (i_req || d_req) begin
            vectors++; errors++;
            $display("FAIL fill_timeout: no fill_vld within %0d cycles (i_req %b d_req %b)", budget, i_req, d_req);
            i_req = 0; d_req = 0;
        end
        if (had_d && exp_d >= 0) check("latency_d", ld, exp_d);
        if (had_i && exp_i >= 0) check("latency_i", li, exp_i);
    endtask

    task automatic serve(input logic do_i, input logic do_d, input logic dirty,
                         input logic [AW-1:0] ia, input logic [AW-1:0] da,
                         input logic [AW-1:0] va, input logic [DW-1:0] vd,
                         input int exp_d, input int exp_i);
        @(negedge clk);
        start_req(do_i, do_d, dirty, ia, da, va, vd);
        wait_done(exp_d, exp_i, 100);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_mem_re"}, mem_re, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_fill_data"}, fill_data, 0);
        check({tag, "_mem_err"}, mem_err, 0);
        check({tag, "_vld"}, {i_fill_vld, d_fill_vld}, 0);
    endtask

    initial begin
        int r0, w0, kind, ed, ei;
        logic dr, di, dd;
        logic [AW-1:0] ra, rb, rv;
        logic [DW-1:0] rvd;
        rst = 1; i_req = 0; d_req = 0; d_dirty = 0;
        i_line_addr = '0; d_line_addr = '0; d_vic_addr = '0; d_vic_data = '0;
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_line(i);
        ref_mem[14'h0010] = 64'h0004_0003_0002_0001;
        @(negedge clk);
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 0;

        // 1: clean D fill
        r0 = rd_cnt; w0 = wr_cnt;
        serve(0, 1, 0, '0, 14'h0010, '0, '0, 6, -1);
        check("t1_reads", rd_cnt - r0, 1);
        check("t1_writes", wr_cnt - w0, 0);

        // 2: dirty D: writeback then fill
        r0 = rd_cnt; w0 = wr_cnt;
        serve(0, 1, 1, '0, 14'h0030, 14'h0020, 64'hDEAD_BEEF_CAFE_F00D, 11, -1);
        check("t2_reads", rd_cnt - r0, 1);
        check("t2_writes", wr_cnt - w0, 1);
        check("t2_mem_line", mem[14'h0020], 64'hDEAD_BEEF_CAFE_F00D);

        // 3: simultaneous I and D
        serve(1, 1, 0, 14'h0040, 14'h0050, '0, '0, 6, 13);
        check("err_clear_normal", mem_err, 0);

        // 4: long memory stall trips the watchdog
        stall_next = 20;
        serve(0, 1, 0, '0, 14'h0060, '0, '0, -1, -1);
        stall_next = 0;
        check("t4_mem_err_set", mem_err, 1);
        serve(1, 0, 0, 14'h0061, '0, '0, '0, -1, 6);
        check("t4_mem_err_sticky", mem_err, 1);

        // 5: reset in WB_WAIT; the write still lands, next request waits for rdy
        @(negedge clk);
        start_req(0, 1, 1, '0, 14'h0070, 14'h0071, 64'h0123_4567_89AB_CDEF);
        void'(fill_q.pop_back());
        repeat (3) @(negedge clk);
        check("t5_busy_before_rst", busy, 1);
        rst = 1; d_req = 0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst = 0;
        start_req(0, 1, 0, '0, 14'h0072, '0, '0);
        wait_done(7, -1, 100);
        check("t5_inflight_write", mem[14'h0071], 64'h0123_4567_89AB_CDEF);
        check("t5_mem_err_cleared", mem_err, 0);

        // 6: back-to-back I misses
        r0 = rd_cnt;
        serve(1, 0, 0, 14'h0001, '0, '0, '0, -1, 6);
        serve(1, 0, 0, 14'h0002, '0, '0, '0, -1, 6);
        check("t6_reads", rd_cnt - r0, 2);

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 3);
            di = (kind == 0) || (kind == 3);
            dd = (kind != 0);
            dr = (kind == 2) || ((kind == 3) && ($urandom_range(0, 1) == 1));
            ra = AW'($urandom); rb = AW'($urandom); rv = AW'($urandom);
            rvd = {$urandom, $urandom};
            ed = dr ? 11 : 6;
            ei = dd ? ed + 7 : 6;
            serve(di, dd, dr, ra, rb, rv, rvd, ed, ei);
        end

        repeat (3) @(negedge clk);
        check("end_mem_err", mem_err, 0);
        check("end_fill_q_empty", fill_q.size(), 0);
        check("end_wb_q_empty", wb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
